eth_latency_log_fifo: RTL and testbench
=======================================

ETH_LATENCY_LOG_FIFO -- requirements
Module: eth_latency_log_fifo

Interface
REQ-001 Parameter C_AXIS_WIDTH, default 64, data width of log stream words.
REQ-002 Parameter C_DEPTH, default 256, FIFO depth in words; power of two, >= 4.
REQ-003 Port clk  input  1  sole clock; all logic synchronous to its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port s_axis_tdata  input  C_AXIS_WIDTH  log word from measurer log stream.
REQ-006 Port s_axis_tlast  input  1  last word of a log record.
REQ-007 Port s_axis_tvalid  input  1  word valid.
REQ-008 Port s_axis_tready  output  1  always 1 outside reset; overflow handled by dropping, never by stalling.
REQ-009 Port m_axis_tdata  output  C_AXIS_WIDTH  buffered word toward DMA/consumer.
REQ-010 Port m_axis_tlast  output  1  last word of record.
REQ-011 Port m_axis_tvalid  output  1  word valid.
REQ-012 Port m_axis_tready  input  1  consumer ready.
REQ-013 Port occupancy  output  $clog2(C_DEPTH)+1  committed words stored, including output register.
REQ-014 Port drop_count  output  64  records dropped since reset, saturating.
REQ-015 Port drop_pulse  output  1  one-cycle pulse per dropped record.

Function
REQ-016 SHALL store only complete records; write pointer advances tentatively per word, committed pointer updates only on accepted tlast word.
REQ-017 SHALL implement write FSM states ST_IDLE, ST_RECORD, ST_DROP.
REQ-018 ST_IDLE: valid word with free space -> store; tlast -> commit, stay ST_IDLE; else -> ST_RECORD.
REQ-019 ST_RECORD: valid word with free space -> store; tlast -> commit, ST_IDLE.
REQ-020 Any state, valid word with no free space (tentative pointer == read pointer + C_DEPTH) -> discard word, rewind tentative pointer to committed pointer; tlast on that word -> ST_IDLE with drop registered, else -> ST_DROP.
REQ-021 ST_DROP: discard words; on tlast -> ST_IDLE, drop registered.
REQ-022 A drop SHALL assert drop_pulse the cycle after the tlast of the dropped record and increment drop_count same cycle; drop_count saturates at 2^64-1.
REQ-023 Record of exactly the free space SHALL be accepted (FIFO full afterwards); record longer than C_DEPTH always dropped.
REQ-024 Read side: committed word reaches m_axis_tvalid exactly 2 cycles after commit cycle when output empty (RAM read + output register).
REQ-025 m_axis_tdata/tlast/tvalid SHALL stay stable while tvalid=1 and tready=0; back-to-back transfer at 1 word/cycle when tready held high.
REQ-026 Simultaneous commit and read SHALL both take effect; space freed by a read becomes usable the next cycle.
REQ-027 Pointers SHALL be $clog2(C_DEPTH)+1 bits, wrap naturally; full/empty from MSB comparison.
REQ-028 occupancy SHALL reflect commit and read in the cycle after they occur; uncommitted words excluded.

Reset
REQ-029 rst SHALL clear all pointers, FSM to ST_IDLE, drop_count=0, drop_pulse=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, occupancy=0, s_axis_tready=0.
REQ-030 s_axis_tready SHALL return to 1 the cycle after rst deasserts; partial record in flight at reset is lost and not counted as drop.
REQ-031 RAM contents need no reset.

Configuration
REQ-032 Macro ETH_LATENCY_LOG_FIFO_DROP_COUNT_EN: defined -> drop_count and drop_pulse behave per REQ-022; undefined -> both tied to 0, counter logic not synthesized, dropping behaviour unchanged.

Structure
REQ-033 Write FSM state enum typedef and default width/depth constants SHALL live in shared package eth_latency_measurer_pkg.
REQ-034 Storage SHALL be sub-module eth_latency_log_fifo_ram: simple dual-port, one write port, one registered read port, same clk.

Verification
REQ-035 C_DEPTH=16; three 4-word records 0x1..0xC, tready=1 -> identical 12 words out, tlast on words 4/8/12, first tvalid 2 cycles after first commit.
REQ-036 tready=0; four 4-word records then a fifth -> FIFO full at 16, fifth dropped, drop_count=1, drop_pulse one cycle, occupancy=16.
REQ-037 tready=0; 12 words stored, then 4-word record -> accepted exactly, occupancy=16, drop_count=0.
REQ-038 20-word record into empty FIFO -> dropped, occupancy stays 0, subsequent 2-word record delivered intact.
REQ-039 rst asserted after 2 words of a 4-word record -> occupancy=0, m_axis_tvalid=0, drop_count=0; next record delivered intact.
REQ-040 Build without ETH_LATENCY_LOG_FIFO_DROP_COUNT_EN, repeat REQ-036 -> same output stream, drop_count=0, drop_pulse never asserted.

Source files
------------

// File: rtl/eth_latency_measurer_pkg.sv
// Shared types and default sizing for the latency measurer log path.
package eth_latency_measurer_pkg;

    localparam int LOG_AXIS_WIDTH = 64;
    localparam int LOG_FIFO_DEPTH = 256;
    localparam int DROP_COUNT_W   = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_DROP   = 2'd2
    } log_wr_state_e;

endpackage

// File: rtl/eth_latency_log_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port, single clock.
module eth_latency_log_fifo_ram #(
    parameter int DW = 65,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Read data holds when rd_en is low; the read pipeline relies on that to park a word.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/eth_latency_log_fifo.sv
// Record-granular log FIFO: words are committed only when a whole record fits, otherwise
// the record is dropped. Define ETH_LATENCY_LOG_FIFO_DROP_COUNT_EN for drop statistics.
module eth_latency_log_fifo
    import eth_latency_measurer_pkg::*;
#(
    parameter int C_AXIS_WIDTH = LOG_AXIS_WIDTH,
    parameter int C_DEPTH      = LOG_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [C_AXIS_WIDTH-1:0]   s_axis_tdata,
    input  logic                      s_axis_tlast,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [C_AXIS_WIDTH-1:0]   m_axis_tdata,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [$clog2(C_DEPTH):0]  occupancy,
    output logic [DROP_COUNT_W-1:0]   drop_count,
    output logic                      drop_pulse
);

    localparam int AW = $clog2(C_DEPTH);
    localparam int PW = AW + 1;
    localparam int RW = C_AXIS_WIDTH + 1;

    log_wr_state_e state, state_nxt;

    // wr_ptr: tentative, cm_ptr: committed, fetch_ptr: next RAM read, rd_ptr: consumer-released
    logic [PW-1:0] wr_ptr, wr_ptr_nxt, cm_ptr, cm_ptr_nxt, fetch_ptr, rd_ptr;

    logic          s_ready;
    logic          in_fire;
    logic          full;
    logic          ram_wr;
    logic          ram_rd;
    logic          ram_mv;
    logic          out_fire;
    logic [RW-1:0] ram_q;
    logic [RW-1:0] out_word;
    logic [1:0]    vld_pipe;  // [0] RAM read data parked, [1] output register

    assign in_fire  = s_axis_tvalid & s_ready;
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        cm_ptr_nxt = cm_ptr;
        ram_wr     = 1'b0;
        if (in_fire) begin
            if (state == ST_DROP) begin
                if (s_axis_tlast) state_nxt = ST_IDLE;
            end else if (full) begin
                // Record cannot fit: forget its stored words and swallow the rest.
                wr_ptr_nxt = cm_ptr;
                state_nxt  = s_axis_tlast ? ST_IDLE : ST_DROP;
            end else begin
                ram_wr     = 1'b1;
                wr_ptr_nxt = wr_ptr + PW'(1);
                if (s_axis_tlast) begin
                    cm_ptr_nxt = wr_ptr + PW'(1);
                    state_nxt  = ST_IDLE;
                end else begin
                    state_nxt  = ST_RECORD;
                end
            end
        end
    end

    eth_latency_log_fifo_ram #(
        .DW (RW),
        .AW (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_wr),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data ({s_axis_tlast, s_axis_tdata}),
        .rd_en   (ram_rd),
        .rd_addr (fetch_ptr[AW-1:0]),
        .rd_data (ram_q)
    );

    // Two-deep read pipeline; a new read is only issued if the parked word moves on this cycle.
    assign out_fire = vld_pipe[1] & m_axis_tready;
    assign ram_mv   = vld_pipe[0] & (~vld_pipe[1] | m_axis_tready);
    assign ram_rd   = (cm_ptr != fetch_ptr) & (~vld_pipe[0] | ram_mv);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            cm_ptr    <= '0;
            fetch_ptr <= '0;
            rd_ptr    <= '0;
            vld_pipe  <= '0;
            out_word  <= '0;
            s_ready   <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr_nxt;
            cm_ptr      <= cm_ptr_nxt;
            s_ready     <= 1'b1;
            if (ram_rd)   fetch_ptr <= fetch_ptr + PW'(1);
            if (out_fire) rd_ptr    <= rd_ptr + PW'(1);
            vld_pipe[0] <= ram_rd | (vld_pipe[0] & ~ram_mv);
            vld_pipe[1] <= ram_mv | (vld_pipe[1] & ~out_fire);
            if (ram_mv)   out_word  <= ram_q;
        end
    end

    assign s_axis_tready = s_ready;
    assign m_axis_tvalid = vld_pipe[1];
    assign m_axis_tlast  = out_word[RW-1];
    assign m_axis_tdata  = out_word[C_AXIS_WIDTH-1:0];
    assign occupancy     = cm_ptr - rd_ptr;

`ifdef ETH_LATENCY_LOG_FIFO_DROP_COUNT_EN
    logic                    drop_evt;
    logic [DROP_COUNT_W-1:0] drop_cnt_q;
    logic                    drop_pulse_q;

    // A drop is registered on the tlast of the discarded record.
    assign drop_evt = in_fire & s_axis_tlast & ((state == ST_DROP) | full);

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q   <= '0;
            drop_pulse_q <= 1'b0;
        end else begin
            drop_pulse_q <= drop_evt;
            if (drop_evt && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + DROP_COUNT_W'(1);
        end
    end

    assign drop_count = drop_cnt_q;
    assign drop_pulse = drop_pulse_q;
`else
    assign drop_count = '0;
    assign drop_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_eth_latency_log_fifo.sv
// Randomized bench for eth_latency_log_fifo (C_DEPTH=16) against a queue-based record model.
module tb_eth_latency_log_fifo;

    localparam int W  = 64;
    localparam int D  = 16;
    localparam int OW = $clog2(D) + 1;
`ifdef ETH_LATENCY_LOG_FIFO_DROP_COUNT_EN
    localparam bit DC_EN = 1'b1;
`else
    localparam bit DC_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  s_axis_tdata = '0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [W-1:0]  m_axis_tdata;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic [OW-1:0] occupancy;
    logic [63:0]   drop_count;
    logic          drop_pulse;

    eth_latency_log_fifo #(.C_AXIS_WIDTH(W), .C_DEPTH(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .occupancy     (occupancy),
        .drop_count    (drop_count),
        .drop_pulse    (drop_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: committed words awaiting delivery, and the record being assembled.
    logic [W:0]       stored[$];
    logic [W:0]       pend[$];
    bit               dropping   = 1'b0;
    longint unsigned  n_drops    = 0;
    bit               exp_pulse  = 1'b0;
    bit               exp_tready = 1'b0;
    bit               mon_en     = 1'b0;
    bit               hold       = 1'b0;
    logic [W:0]       hold_word;
    int               n_out       = 0;
    int               n_committed = 0;
    int               occ0;
    bit               rnd_on = 1'b0;
    int               rdy_pct = 5;

    // Compare state after the last edge, then advance the model across the next edge.
    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            if (s_axis_tready !== exp_tready) begin
                n_fail++; $display("FAIL tready: got %b want %b", s_axis_tready, exp_tready);
            end
            n_checks++;
            if (occupancy !== OW'(stored.size())) begin
                n_fail++; $display("FAIL occupancy: got %0d want %0d", occupancy, stored.size());
            end
            n_checks++;
            if (drop_count !== (DC_EN ? n_drops : 64'd0)) begin
                n_fail++; $display("FAIL drop_count: got %0d want %0d", drop_count, DC_EN ? n_drops : 64'd0);
            end
            n_checks++;
            if (drop_pulse !== (DC_EN & exp_pulse)) begin
                n_fail++; $display("FAIL drop_pulse: got %b want %b", drop_pulse, DC_EN & exp_pulse);
            end
            if (stored.size() == 0) begin
                n_checks++;
                if (m_axis_tvalid !== 1'b0) begin
                    n_fail++; $display("FAIL tvalid_empty: got %b want 0", m_axis_tvalid);
                end
            end
            if (hold) begin
                n_checks++;
                if (m_axis_tvalid !== 1'b1 || {m_axis_tlast, m_axis_tdata} !== hold_word) begin
                    n_fail++; $display("FAIL stall_stable: got v=%b %0h want v=1 %0h",
                                       m_axis_tvalid, {m_axis_tlast, m_axis_tdata}, hold_word);
                end
            end
        end
        exp_pulse = 1'b0;
        hold      = 1'b0;
        if (rst) begin
            stored.delete();
            pend.delete();
            dropping   = 1'b0;
            n_drops    = 0;
            exp_tready = 1'b0;
        end else begin
            exp_tready = 1'b1;
            occ0 = stored.size();
            if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
                n_checks++;
                if (stored.size() == 0) begin
                    n_fail++; $display("FAIL out_unexpected: got %0h want none", m_axis_tdata);
                end else begin
                    if ({m_axis_tlast, m_axis_tdata} !== stored[0]) begin
                        n_fail++; $display("FAIL out_word: got %0h want %0h", {m_axis_tlast, m_axis_tdata}, stored[0]);
                    end
                    void'(stored.pop_front());
                end
                n_out++;
            end
            if (m_axis_tvalid === 1'b1 && !m_axis_tready) begin
                hold = 1'b1;
                hold_word = {m_axis_tlast, m_axis_tdata};
            end
            if (s_axis_tvalid && s_axis_tready === 1'b1) begin
                if (dropping) begin
                    if (s_axis_tlast) begin dropping = 1'b0; exp_pulse = 1'b1; n_drops++; end
                end else if (occ0 + pend.size() >= D) begin
                    pend.delete();
                    if (s_axis_tlast) begin exp_pulse = 1'b1; n_drops++; end
                    else dropping = 1'b1;
                end else begin
                    pend.push_back({s_axis_tlast, s_axis_tdata});
                    if (s_axis_tlast) begin
                        foreach (pend[i]) stored.push_back(pend[i]);
                        n_committed += pend.size();
                        pend.delete();
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_word(input logic [W-1:0] d, input logic l);
        s_axis_tdata = d; s_axis_tlast = l; s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    endtask

    task automatic send_record(input int len, input logic [W-1:0] base);
        for (int i = 0; i < len; i++) send_word(base + W'(i), i == len - 1);
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    endtask

    task automatic drain(input string name);
        int budget = 200;
        m_axis_tready = 1'b1;
        while ((stored.size() != 0 || m_axis_tvalid === 1'b1) && budget > 0) begin
            tick(); budget--;
        end
        n_checks++;
        if (budget == 0) begin
            n_fail++; $display("FAIL %s drain_timeout: occupancy %0d, want 0", name, occupancy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; m_axis_tready = 1'b0; tick(); tick();
        n_checks++;
        if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL rst_tready: got %b want 0", s_axis_tready); end
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== '0) begin
            n_fail++; $display("FAIL rst_out: got v=%b l=%b d=%0h want 0", m_axis_tvalid, m_axis_tlast, m_axis_tdata);
        end
        n_checks++;
        if (occupancy !== '0) begin n_fail++; $display("FAIL rst_occ: got %0d want 0", occupancy); end
        n_checks++;
        if (drop_count !== 64'd0 || drop_pulse !== 1'b0) begin
            n_fail++; $display("FAIL rst_drop: got %0d/%b want 0/0", drop_count, drop_pulse);
        end
        rst = 1'b0; tick();
        n_checks++;
        if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL rst_release_tready: got %b want 1", s_axis_tready); end
    endtask

    task automatic test_basic();
        int n0;
        do_reset(); m_axis_tready = 1'b1; n0 = n_out;
        send_record(4, 64'h1);
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL lat_c0: got %b want 0", m_axis_tvalid); end
        tick();
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL lat_c1: got %b want 0", m_axis_tvalid); end
        tick();
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'h1) begin
            n_fail++; $display("FAIL lat_c2: got v=%b d=%0h want v=1 d=1", m_axis_tvalid, m_axis_tdata);
        end
        send_record(4, 64'h5);
        send_record(4, 64'h9);
        drain("basic");
        n_checks++;
        if (n_out - n0 != 12) begin n_fail++; $display("FAIL basic_count: got %0d want 12", n_out - n0); end
    endtask

    task automatic test_full_drop();
        int n0;
        do_reset(); m_axis_tready = 1'b0; n0 = n_out;
        for (int r = 0; r < 5; r++) send_record(4, {$urandom, $urandom});
        n_checks++;
        if (drop_pulse !== DC_EN) begin n_fail++; $display("FAIL full_pulse: got %b want %b", drop_pulse, DC_EN); end
        n_checks++;
        if (drop_count !== 64'(DC_EN)) begin n_fail++; $display("FAIL full_count: got %0d want %0d", drop_count, DC_EN); end
        n_checks++;
        if (occupancy !== OW'(16)) begin n_fail++; $display("FAIL full_occ: got %0d want 16", occupancy); end
        tick();
        n_checks++;
        if (drop_pulse !== 1'b0) begin n_fail++; $display("FAIL full_pulse_width: got %b want 0", drop_pulse); end
        drain("full_drop");
        n_checks++;
        if (n_out - n0 != 16) begin n_fail++; $display("FAIL full_count_out: got %0d want 16", n_out - n0); end
    endtask

    task automatic test_exact_fit();
        int n0;
        do_reset(); m_axis_tready = 1'b0; n0 = n_out;
        for (int r = 0; r < 3; r++) send_record(4, {$urandom, $urandom});
        n_checks++;
        if (occupancy !== OW'(12)) begin n_fail++; $display("FAIL fit_occ12: got %0d want 12", occupancy); end
        send_record(4, {$urandom, $urandom});
        n_checks++;
        if (occupancy !== OW'(16) || drop_count !== 64'd0) begin
            n_fail++; $display("FAIL fit_exact: got occ=%0d drops=%0d want 16/0", occupancy, drop_count);
        end
        send_record(1, {$urandom, $urandom});
        n_checks++;
        if (drop_count !== 64'(DC_EN) || occupancy !== OW'(16)) begin
            n_fail++; $display("FAIL fit_overflow1: got drops=%0d occ=%0d want %0d/16", drop_count, occupancy, DC_EN);
        end
        drain("exact_fit");
        n_checks++;
        if (n_out - n0 != 16) begin n_fail++; $display("FAIL fit_count_out: got %0d want 16", n_out - n0); end
    endtask

    task automatic test_oversize();
        int n0;
        do_reset(); m_axis_tready = 1'b1; n0 = n_out;
        send_record(20, {$urandom, $urandom});
        tick();
        n_checks++;
        if (occupancy !== '0 || drop_count !== 64'(DC_EN)) begin
            n_fail++; $display("FAIL oversize: got occ=%0d drops=%0d want 0/%0d", occupancy, drop_count, DC_EN);
        end
        send_record(2, {$urandom, $urandom});
        drain("oversize");
        n_checks++;
        if (n_out - n0 != 2) begin n_fail++; $display("FAIL oversize_next: got %0d want 2", n_out - n0); end
    endtask

    task automatic test_reset_midrecord();
        int n0;
        do_reset(); m_axis_tready = 1'b1;
        send_word(64'hA1, 1'b0);
        send_word(64'hA2, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0; tick();
        n_checks++;
        if (occupancy !== '0 || m_axis_tvalid !== 1'b0 || drop_count !== 64'd0) begin
            n_fail++; $display("FAIL midrst: got occ=%0d v=%b drops=%0d want 0/0/0", occupancy, m_axis_tvalid, drop_count);
        end
        n0 = n_out;
        send_record(4, 64'hB0);
        drain("midrst");
        n_checks++;
        if (n_out - n0 != 4) begin n_fail++; $display("FAIL midrst_next: got %0d want 4", n_out - n0); end
    endtask

    task automatic test_back_to_back();
        do_reset(); m_axis_tready = 1'b0;
        send_record(4, 64'h100);
        send_record(4, 64'h200);
        tick(); tick(); tick();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_word%0d: got v=%b want 1", i, m_axis_tvalid); end
            tick();
        end
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got v=%b want 0", m_axis_tvalid); end
    endtask

    task automatic test_random();
        int n0, c0;
        do_reset(); n0 = n_out; c0 = n_committed;
        rnd_on = 1'b1;
        fork
            while (rnd_on) begin
                m_axis_tready = ($urandom_range(0, 9) < rdy_pct);
                tick();
            end
        join_none
        for (int r = 0; r < 40; r++) begin
            int len;
            rdy_pct = (r < 20) ? 2 : 8;
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) begin
                while ($urandom_range(0, 3) == 0) tick();
                send_word({$urandom, $urandom}, i == len - 1);
            end
        end
        rnd_on = 1'b0;
        tick();
        drain("random");
        n_checks++;
        if (n_out - n0 != n_committed - c0) begin
            n_fail++; $display("FAIL random_count: got %0d want %0d", n_out - n0, n_committed - c0);
        end
    endtask

    initial begin
        tick();
        test_reset();
        mon_en = 1'b1;
        test_basic();
        test_full_drop();
        test_exact_fit();
        test_oversize();
        test_reset_midrecord();
        test_back_to_back();
        test_random();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
